maxpool_window_sequencer: RTL and testbench

//  Control-only sequencer for the 2x2, stride-2 max-pool stage behind a conv layer.

---
 rtl/maxpool_window_sequencer_if.sv | 32 +++
 rtl/maxpool_window_sequencer.sv | 132 +++++++++++++
 tb/tb_maxpool_window_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_window_sequencer_if.sv
// Handshake, position and strobe bundle between the max-pool sequencer and its
// surroundings. The sequencer takes the slave side; the stream driver and consumer take master.
interface maxpool_window_sequencer_if #(
  parameter int CNT_WIDTH = 14
);
  logic                 Start;
  logic                 In_Valid;
  logic                 In_Ready;
  logic                 Out_Ready;
  logic                 Out_Valid;
  logic [CNT_WIDTH-1:0] Col_Cnt;
  logic [CNT_WIDTH-1:0] Row_Cnt;
  logic [CNT_WIDTH-1:0] Lb_Addr;
  logic                 Pair_Load;
  logic                 Pair_Cmp;
  logic                 Lb_Wr_En;
  logic                 Win_Done;
  logic                 Busy;
  logic                 Done;

  modport master (
    output Start, In_Valid, Out_Ready,
    input  In_Ready, Out_Valid, Col_Cnt, Row_Cnt, Lb_Addr,
    input  Pair_Load, Pair_Cmp, Lb_Wr_En, Win_Done, Busy, Done
  );

  modport slave (
    input  Start, In_Valid, Out_Ready,
    output In_Ready, Out_Valid, Col_Cnt, Row_Cnt, Lb_Addr,
    output Pair_Load, Pair_Cmp, Lb_Wr_En, Win_Done, Busy, Done
  );
endinterface

// File: rtl/maxpool_window_sequencer.sv
// Control sequencer for a 2x2 stride-2 max-pool: follows the raster position of the
// incoming pixel stream and issues pair/line-buffer/window strobes with output backpressure.
module maxpool_window_sequencer #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int CNT_WIDTH = 14
) (
  input logic                      Clk,
  input logic                      Rst,
  maxpool_window_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_W - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_H - 1);
  // First column/row index excluded from pooling; equals the size when it is even.
  localparam logic [CNT_WIDTH-1:0] COL_POOL = CNT_WIDTH'(IMG_W - (IMG_W % 2));
  localparam logic [CNT_WIDTH-1:0] ROW_POOL = CNT_WIDTH'(IMG_H - (IMG_H % 2));

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] col_cnt, col_nxt;
  logic [CNT_WIDTH-1:0] row_cnt, row_nxt;
  logic                 out_valid, out_valid_nxt;
  logic                 done_q, done_nxt;
  logic                 in_ready;
  logic                 accept;
  logic                 col_pooled;
  logic                 row_pooled;
  logic                 pair_load;
  logic                 pair_cmp;
  logic                 lb_wr_en;
  logic                 win_done;

  always_comb begin
    in_ready   = (state == RUN) && !(out_valid && !bus.Out_Ready);
    accept     = bus.In_Valid && in_ready;
    col_pooled = (col_cnt < COL_POOL);
    row_pooled = (row_cnt < ROW_POOL);
    pair_load  = accept && col_pooled && !col_cnt[0];
    pair_cmp   = accept && col_pooled && col_cnt[0];
    lb_wr_en   = pair_cmp && !row_cnt[0];
    win_done   = pair_cmp && row_cnt[0] && row_pooled;
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col_cnt;
    row_nxt   = row_cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          state_nxt = RUN;
          col_nxt   = '0;
          row_nxt   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (col_cnt == COL_LAST) begin
            col_nxt = '0;
            if (row_cnt == ROW_LAST) begin
              row_nxt   = '0;
              state_nxt = FLUSH;
            end else begin
              row_nxt = row_cnt + 1'b1;
            end
          end else begin
            col_nxt = col_cnt + 1'b1;
          end
        end
      end
      FLUSH: begin
        // Frame ends once no pooled value is left waiting for the consumer.
        if (!out_valid || bus.Out_Ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          col_nxt   = '0;
          row_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        col_nxt   = '0;
        row_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    out_valid_nxt = out_valid;
    if (win_done) begin
      out_valid_nxt = 1'b1;
    end else if (out_valid && bus.Out_Ready) begin
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_cnt   <= col_nxt;
      row_cnt   <= row_nxt;
      out_valid <= out_valid_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.In_Ready  = in_ready;
  assign bus.Out_Valid = out_valid;
  assign bus.Col_Cnt   = col_cnt;
  assign bus.Row_Cnt   = row_cnt;
  assign bus.Lb_Addr   = col_cnt >> 1;
  assign bus.Pair_Load = pair_load;
  assign bus.Pair_Cmp  = pair_cmp;
  assign bus.Lb_Wr_En  = lb_wr_en;
  assign bus.Win_Done  = win_done;
  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_maxpool_window_sequencer.sv
// Self-checking bench for maxpool_window_sequencer: a 4x4 and a 5x3 instance driven
// with directed and random streams and compared against a raster-index reference model.
module tb_maxpool_window_sequencer;

  localparam int CW = 14;

  logic Clk;
  logic Rst;
  int   vectors;
  int   miscompares;

  maxpool_window_sequencer_if #(.CNT_WIDTH(CW)) if4 ();
  maxpool_window_sequencer_if #(.CNT_WIDTH(CW)) if53 ();

  maxpool_window_sequencer #(.IMG_W(4), .IMG_H(4), .CNT_WIDTH(CW)) dut4 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (if4.slave)
  );

  maxpool_window_sequencer #(.IMG_W(5), .IMG_H(3), .CNT_WIDTH(CW)) dut53 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (if53.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: strobes {load, cmp, wr, win} for the k-th pixel of a w x h raster frame.
  function automatic logic [3:0] ref_strobes(input int k, input int w, input int h);
    int r;
    int c;
    bit pc;
    bit pr;
    bit cmp;
    r   = k / w;
    c   = k % w;
    pc  = (c < w - (w % 2));
    pr  = (r < h - (h % 2));
    cmp = pc && (c % 2 == 1);
    return {pc && (c % 2 == 0), cmp, cmp && (r % 2 == 0), cmp && (r % 2 == 1) && pr};
  endfunction

  // A pooled value must never be produced while the previous one is being taken.
  always @(negedge Clk) begin
    #2;
    if (if4.Win_Done && if4.Out_Valid && if4.Out_Ready) begin
      miscompares++;
      $display("[TB] FAIL set_clear_collision dut4 got=1 exp=0");
    end
    if (if53.Win_Done && if53.Out_Valid && if53.Out_Ready) begin
      miscompares++;
      $display("[TB] FAIL set_clear_collision dut53 got=1 exp=0");
    end
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    #1;
    vectors++;
    if ({if4.In_Ready, if4.Out_Valid, if4.Busy, if4.Done, if4.Pair_Load, if4.Pair_Cmp,
         if4.Lb_Wr_En, if4.Win_Done} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got=%b exp=00000000",
               {if4.In_Ready, if4.Out_Valid, if4.Busy, if4.Done, if4.Pair_Load,
                if4.Pair_Cmp, if4.Lb_Wr_En, if4.Win_Done});
    end
    vectors++;
    if ({if4.Row_Cnt, if4.Col_Cnt, if4.Lb_Addr} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0",
               if4.Row_Cnt, if4.Col_Cnt, if4.Lb_Addr);
    end
    vectors++;
    if ({if53.In_Ready, if53.Out_Valid, if53.Busy, if53.Done} !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_5x3 got=%b exp=0000",
               {if53.In_Ready, if53.Out_Valid, if53.Busy, if53.Done});
    end
    @(negedge Clk);
    Rst = 1'b0;
    if4.In_Valid = 1'b1;
    tick();
    #1;
    vectors++;
    if ({if4.In_Ready, if4.Busy, if4.Pair_Load} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL idle_without_start got=%b exp=000",
               {if4.In_Ready, if4.Busy, if4.Pair_Load});
    end
    if4.In_Valid = 1'b0;
    tick();
  endtask

  // vmode: 0 continuous, 1 alternating, 2 random valid; rmode: 0 always ready, 1 random.
  task automatic test_frame(input string name, input int vmode, input int rmode,
                            input int stall_len, input bit start_mid);
    int acc, made, taken, obs_hs, stall_left;
    bit stall_used, start_sent, done_due, done_seen, exp_ov, exp_ir, exp_acc, flush;
    logic [3:0] exp_stb, exp_flags, obs_flags, obs_stb;
    logic [3*CW-1:0] exp_cnt;
    acc = 0; made = 0; taken = 0; obs_hs = 0; stall_left = 0;
    stall_used = 0; start_sent = 0; done_due = 0; done_seen = 0;
    if4.Start = 1'b1;
    if4.In_Valid = 1'b0;
    if4.Out_Ready = 1'b1;
    #1;
    vectors++;
    if ({if4.Busy, if4.In_Ready} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL %s idle_at_start got=%b exp=00", name, {if4.Busy, if4.In_Ready});
    end
    tick();
    if4.Start = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      exp_ov = (made > taken);
      if (exp_ov && stall_len > 0 && !stall_used) begin
        stall_left = stall_len;
        stall_used = 1'b1;
      end
      case (vmode)
        0:       if4.In_Valid = 1'b1;
        1:       if4.In_Valid = (cyc % 2 == 0);
        default: if4.In_Valid = ($urandom_range(0, 3) != 0);
      endcase
      if (stall_left > 0) begin
        if4.Out_Ready = 1'b0;
        stall_left--;
      end else begin
        if4.Out_Ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      if4.Start = start_mid && !start_sent && (acc == 5);
      if (if4.Start) start_sent = 1'b1;
      #1;
      exp_ir    = (acc < 16) && !(exp_ov && !if4.Out_Ready);
      exp_acc   = exp_ir && if4.In_Valid;
      exp_stb   = exp_acc ? ref_strobes(acc, 4, 4) : 4'b0000;
      exp_flags = {exp_ir, exp_ov, !done_due, done_due};
      obs_flags = {if4.In_Ready, if4.Out_Valid, if4.Busy, if4.Done};
      obs_stb   = {if4.Pair_Load, if4.Pair_Cmp, if4.Lb_Wr_En, if4.Win_Done};
      vectors++;
      if (obs_flags !== exp_flags) begin
        miscompares++;
        $display("[TB] FAIL %s flags acc=%0d got=%b exp=%b", name, acc, obs_flags, exp_flags);
      end
      vectors++;
      if (obs_stb !== exp_stb) begin
        miscompares++;
        $display("[TB] FAIL %s strobes acc=%0d got=%b exp=%b", name, acc, obs_stb, exp_stb);
      end
      if (acc < 16 || done_due) begin
        exp_cnt = done_due ? '0 : {CW'(acc / 4), CW'(acc % 4), CW'((acc % 4) / 2)};
        vectors++;
        if ({if4.Row_Cnt, if4.Col_Cnt, if4.Lb_Addr} !== exp_cnt) begin
          miscompares++;
          $display("[TB] FAIL %s counters acc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", name, acc,
                   if4.Row_Cnt, if4.Col_Cnt, if4.Lb_Addr, exp_cnt[3*CW-1:2*CW],
                   exp_cnt[2*CW-1:CW], exp_cnt[CW-1:0]);
        end
      end
      obs_hs += int'(if4.Out_Valid && if4.Out_Ready);
      flush = (acc == 16) && !done_due;
      if (exp_ov && if4.Out_Ready) taken++;
      if (exp_stb[0]) made++;
      if (exp_acc) acc++;
      if (done_due) done_seen = 1'b1;
      done_due = flush && (!exp_ov || if4.Out_Ready);
      tick();
    end
    vectors++;
    if (!done_seen) begin
      miscompares++;
      $display("[TB] FAIL %s frame_timeout got=no_done exp=done", name);
    end
    vectors++;
    if (obs_hs !== 4) begin
      miscompares++;
      $display("[TB] FAIL %s handshakes got=%0d exp=4", name, obs_hs);
    end
    if4.In_Valid = 1'b0;
    if4.Out_Ready = 1'b1;
    repeat (2) begin
      #1;
      vectors++;
      if ({if4.Busy, if4.Done, if4.Out_Valid} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL %s after_done got=%b exp=000", name,
                 {if4.Busy, if4.Done, if4.Out_Valid});
      end
      tick();
    end
  endtask

  task automatic test_odd_dims();
    int acc, made, taken, obs_hs, obs_wd;
    bit done_due, done_seen, exp_ov, flush;
    logic [3:0] exp_stb, exp_flags, obs_flags, obs_stb;
    acc = 0; made = 0; taken = 0; obs_hs = 0; obs_wd = 0;
    done_due = 0; done_seen = 0;
    if53.Start = 1'b1;
    if53.In_Valid = 1'b1;
    if53.Out_Ready = 1'b1;
    tick();
    if53.Start = 1'b0;
    for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
      exp_ov = (made > taken);
      #1;
      exp_stb   = (acc < 15) ? ref_strobes(acc, 5, 3) : 4'b0000;
      exp_flags = {acc < 15, exp_ov, !done_due, done_due};
      obs_flags = {if53.In_Ready, if53.Out_Valid, if53.Busy, if53.Done};
      obs_stb   = {if53.Pair_Load, if53.Pair_Cmp, if53.Lb_Wr_En, if53.Win_Done};
      vectors++;
      if (obs_flags !== exp_flags) begin
        miscompares++;
        $display("[TB] FAIL odd_dims flags acc=%0d got=%b exp=%b", acc, obs_flags, exp_flags);
      end
      vectors++;
      if (obs_stb !== exp_stb) begin
        miscompares++;
        $display("[TB] FAIL odd_dims strobes acc=%0d got=%b exp=%b", acc, obs_stb, exp_stb);
      end
      if (acc < 15) begin
        vectors++;
        if ({if53.Row_Cnt, if53.Col_Cnt} !== {CW'(acc / 5), CW'(acc % 5)}) begin
          miscompares++;
          $display("[TB] FAIL odd_dims counters acc=%0d got=%0d/%0d exp=%0d/%0d", acc,
                   if53.Row_Cnt, if53.Col_Cnt, acc / 5, acc % 5);
        end
      end
      obs_hs += int'(if53.Out_Valid && if53.Out_Ready);
      obs_wd += int'(if53.Win_Done);
      flush = (acc == 15) && !done_due;
      if (exp_ov) taken++;
      if (exp_stb[0]) made++;
      if (acc < 15) acc++;
      if (done_due) done_seen = 1'b1;
      done_due = flush && 1'b1;
      tick();
    end
    vectors++;
    if (!done_seen || obs_wd !== 2 || obs_hs !== 2) begin
      miscompares++;
      $display("[TB] FAIL odd_dims totals got=done:%0b win:%0d hs:%0d exp=done:1 win:2 hs:2",
               done_seen, obs_wd, obs_hs);
    end
    if53.In_Valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    if4.Start = 1'b1;
    if4.In_Valid = 1'b0;
    if4.Out_Ready = 1'b1;
    tick();
    if4.Start = 1'b0;
    if4.In_Valid = 1'b1;
    repeat (7) tick();
    #1;
    vectors++;
    if ({if4.Row_Cnt, if4.Col_Cnt} !== {CW'(1), CW'(3)}) begin
      miscompares++;
      $display("[TB] FAIL midframe_position got=%0d/%0d exp=1/3", if4.Row_Cnt, if4.Col_Cnt);
    end
    Rst = 1'b1;
    #1;
    vectors++;
    if ({if4.In_Ready, if4.Out_Valid, if4.Busy, if4.Done, if4.Pair_Load, if4.Pair_Cmp,
         if4.Lb_Wr_En, if4.Win_Done, if4.Row_Cnt, if4.Col_Cnt} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midframe_reset got=%b r=%0d c=%0d exp=all_zero",
               {if4.In_Ready, if4.Out_Valid, if4.Busy, if4.Done, if4.Pair_Load,
                if4.Pair_Cmp, if4.Lb_Wr_En, if4.Win_Done}, if4.Row_Cnt, if4.Col_Cnt);
    end
    tick();
    Rst = 1'b0;
    if4.In_Valid = 1'b0;
    tick();
    #1;
    vectors++;
    if ({if4.Busy, if4.Done} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL midframe_no_done got=%b exp=00", {if4.Busy, if4.Done});
    end
    tick();
    test_frame("after_reset", 0, 0, 0, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    Rst = 1'b1;
    if4.Start = 1'b0;
    if4.In_Valid = 1'b0;
    if4.Out_Ready = 1'b0;
    if53.Start = 1'b0;
    if53.In_Valid = 1'b0;
    if53.Out_Ready = 1'b0;
    repeat (2) @(negedge Clk);
    test_reset();
    test_frame("continuous", 0, 0, 0, 1'b0);
    test_frame("backpressure", 0, 0, 5, 1'b0);
    test_frame("valid_gaps", 1, 0, 0, 1'b0);
    test_frame("start_in_run", 0, 0, 0, 1'b1);
    test_odd_dims();
    test_reset_midframe();
    for (int i = 0; i < 4; i++) test_frame("random", 2, 1, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
